// File: rtl/grid_io_cfg_pkg.sv
// Shared definitions for the I/O grid configuration bank:
// config bit layout per pad, word-line address width and loader FSM states.
package grid_io_cfg_pkg;

  // Config bits per pad and their word-line indices
  localparam int unsigned CFG_BITS = 3;
  localparam int unsigned CFG_OE   = 0;
  localparam int unsigned CFG_IREG = 1;
  localparam int unsigned CFG_OREG = 2;

  // Word-line address width: max(1, clog2(n))
  function automatic int unsigned calc_aw(input int unsigned n);
    int unsigned w;
    w = int'($clog2(n));
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned AW = calc_aw(CFG_BITS);

  // Loader sequence states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BL_SETUP = 2'd1,
    WL_PULSE = 2'd2,
    BL_HOLD  = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/io_pad_slice.sv
// One pad of the I/O grid column: CFG_BITS config cells written by bl/wl,
// input synchroniser, output register and the pad/fabric muxing.
// Ports:
//   clk, i_reset    : clock, synchronous active-high reset
//   i_bl, i_wl      : bit-line (this pad's data) and one-hot word lines
//   i_pad_in        : pad receiver value
//   i_io_out        : fabric data towards the pad
//   o_pad_out       : pad driver data
//   o_pad_oe        : pad driver enable
//   o_io_in         : pad data towards the fabric
module io_pad_slice
  import grid_io_cfg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_bl,
  input  logic [CFG_BITS-1:0] i_wl,
  input  logic                i_pad_in,
  input  logic                i_io_out,
  output logic                o_pad_out,
  output logic                o_pad_oe,
  output logic                o_io_in
);

  logic [CFG_BITS-1:0]    r_cfg;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_oreg;

  logic w_oe;
  logic w_ireg;
  logic w_oreg_en;

  // Config cells plus free-running synchroniser and output register;
  // the latter keep running regardless of the selected mode.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_cfg  <= '0;
      r_sync <= '0;
      r_oreg <= 1'b0;
    end else begin
      for (int b = 0; b < int'(CFG_BITS); b++) begin
        if (i_wl[b]) r_cfg[b] <= i_bl;
      end
      r_sync[0] <= i_pad_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_oreg <= i_io_out;
    end
  end

  assign w_oe      = r_cfg[CFG_OE];
  assign w_ireg    = r_cfg[CFG_IREG];
  assign w_oreg_en = r_cfg[CFG_OREG];

  // Output-mode pads drive the pad and return 0 to the fabric; input-mode
  // pads do the reverse.
  assign o_pad_oe  = w_oe;
  assign o_pad_out = w_oe & (w_oreg_en ? r_oreg : i_io_out);
  assign o_io_in   = ~w_oe & (w_ireg ? r_sync[SYNC_STAGES-1] : i_pad_in);

endmodule

// File: rtl/grid_io_cfg_bank.sv
// I/O grid column of NUM_IO pads with a built-in configuration loader.
// Frames (word-line address + one bit per pad) arrive on a valid/ready port
// and are written by a fixed BL_SETUP -> WL_PULSE -> BL_HOLD sequence.
// Ports:
//   clk, Reset              : clock, synchronous active-high reset
//   cfg_valid / cfg_ready   : frame handshake
//   cfg_wl_addr             : config bit index to write
//   cfg_bl_data             : one config bit per pad
//   cfg_err                 : sticky out-of-range address flag
//   pad_in / pad_out/pad_oe : pad receiver, driver data, driver enable
//   io_out / io_in          : fabric to pad, pad to fabric
module grid_io_cfg_bank
  import grid_io_cfg_pkg::*;
#(
  parameter int unsigned NUM_IO      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [AW-1:0]     cfg_wl_addr,
  input  logic [NUM_IO-1:0] cfg_bl_data,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] pad_in,
  output logic [NUM_IO-1:0] pad_out,
  output logic [NUM_IO-1:0] pad_oe,
  input  logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_in
);

  cfg_state_e          r_state;
  logic [AW-1:0]       r_addr;
  logic [NUM_IO-1:0]   r_bl;
  logic [CFG_BITS-1:0] r_wl;
  logic                r_err;

  logic w_addr_ok;

  // Ready is withdrawn during reset so no frame is taken on a reset edge.
  assign cfg_ready = (r_state == IDLE) && !Reset;
  assign cfg_err   = r_err;
  assign w_addr_ok = (32'(cfg_wl_addr) < CFG_BITS);

  // Loader FSM; bl is latched on acceptance and held until the next frame.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_bl    <= '0;
      r_wl    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wl <= '0;
          if (cfg_valid) begin
            if (w_addr_ok) begin
              r_addr  <= cfg_wl_addr;
              r_bl    <= cfg_bl_data;
              r_state <= BL_SETUP;
            end else begin
              // Bad frame is consumed but never reaches the array.
              r_err <= 1'b1;
            end
          end
        end
        BL_SETUP: begin
          r_wl    <= CFG_BITS'(1) << r_addr;
          r_state <= WL_PULSE;
        end
        WL_PULSE: begin
          r_wl    <= '0;
          r_state <= BL_HOLD;
        end
        BL_HOLD: begin
          r_state <= IDLE;
        end
        default: begin
          r_wl    <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // One slice per pad; each sees only its own bit-line.
  for (genvar g = 0; g < int'(NUM_IO); g++) begin : g_pad
    io_pad_slice #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_pad (
      .clk       (clk),
      .i_reset   (Reset),
      .i_bl      (r_bl[g]),
      .i_wl      (r_wl),
      .i_pad_in  (pad_in[g]),
      .i_io_out  (io_out[g]),
      .o_pad_out (pad_out[g]),
      .o_pad_oe  (pad_oe[g]),
      .o_io_in   (io_in[g])
    );
  end

endmodule

// File: tb/tb_grid_io_cfg_bank.sv
// Directed self-checking bench for grid_io_cfg_bank (NUM_IO=8, SYNC_STAGES=2).
module tb_grid_io_cfg_bank;

  localparam int unsigned NIO = 8;

  logic           clk;
  logic           Reset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_wl_addr;
  logic [NIO-1:0] cfg_bl_data;
  logic           cfg_err;
  logic [NIO-1:0] pad_in;
  logic [NIO-1:0] pad_out;
  logic [NIO-1:0] pad_oe;
  logic [NIO-1:0] io_out;
  logic [NIO-1:0] io_in;

  int n_total;
  int n_pass;

  grid_io_cfg_bank #(
    .NUM_IO      (NIO),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_wl_addr (cfg_wl_addr),
    .cfg_bl_data (cfg_bl_data),
    .cfg_err     (cfg_err),
    .pad_in      (pad_in),
    .pad_out     (pad_out),
    .pad_oe      (pad_oe),
    .io_out      (io_out),
    .io_in       (io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one frame, waiting (bounded) for ready; returns 1 cycle after the accepting edge.
  task automatic send(input logic [1:0] a, input logic [NIO-1:0] d);
    int n;
    n = 0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", 64'(cfg_ready), 64'd1);
    cfg_valid   = 1'b1;
    cfg_wl_addr = a;
    cfg_bl_data = d;
    tick();
    cfg_valid   = 1'b0;
    cfg_wl_addr = '0;
    cfg_bl_data = '0;
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    Reset       = 1'b1;
    cfg_valid   = 1'b0;
    cfg_wl_addr = '0;
    cfg_bl_data = '0;
    pad_in      = 8'h5A;
    io_out      = 8'h00;
    tick();
    tick();
    Reset = 1'b0;
    #1;

    // 1: reset state
    check("rst_ready",   64'(cfg_ready), 64'd1);
    check("rst_err",     64'(cfg_err),   64'd0);
    check("rst_pad_oe",  64'(pad_oe),    64'h00);
    check("rst_pad_out", 64'(pad_out),   64'h00);
    check("rst_io_in",   64'(io_in),     64'h5A);

    // 2: OE write, ready low for 3 cycles, effect after 2 edges
    send(2'd0, 8'hA5);
    check("t2_ready_c1", 64'(cfg_ready), 64'd0);
    check("t2_oe_c1",    64'(pad_oe),    64'h00);
    tick();
    check("t2_ready_c2", 64'(cfg_ready), 64'd0);
    check("t2_oe_c2",    64'(pad_oe),    64'h00);
    tick();
    check("t2_ready_c3", 64'(cfg_ready), 64'd0);
    check("t2_oe_c3",    64'(pad_oe),    64'hA5);
    tick();
    check("t2_ready_c4", 64'(cfg_ready), 64'd1);
    check("t2_io_in",    64'(io_in),     64'h5A);
    io_out = 8'h3C;
    #1;
    check("t2_pad_out",  64'(pad_out),   64'h24);

    // 3: input synchroniser latency
    Reset  = 1'b1;
    io_out = 8'h00;
    pad_in = 8'h00;
    tick();
    Reset = 1'b0;
    send(2'd1, 8'hFF);
    tick();
    tick();
    tick();
    pad_in = 8'h01;
    #1;
    check("t3_sync_e0", 64'(io_in), 64'h00);
    tick();
    check("t3_sync_e1", 64'(io_in), 64'h00);
    tick();
    check("t3_sync_e2", 64'(io_in), 64'h01);

    // 4: registered output on pads 0..3 only
    send(2'd0, 8'h0F);
    tick();
    tick();
    tick();
    send(2'd2, 8'hFF);
    tick();
    tick();
    tick();
    check("t4_pad_oe", 64'(pad_oe), 64'h0F);
    io_out = 8'h3C;
    #1;
    check("t4_oreg_e0", 64'(pad_out), 64'h00);
    tick();
    check("t4_oreg_e1", 64'(pad_out), 64'h0C);
    check("t4_io_in",   64'(io_in),   64'h00);

    // 5: out-of-range address sets sticky error, no write, no busy period
    send(2'd3, 8'hFF);
    check("t5_err",       64'(cfg_err),   64'd1);
    check("t5_ready",     64'(cfg_ready), 64'd1);
    check("t5_pad_oe",    64'(pad_oe),    64'h0F);
    tick();
    tick();
    tick();
    check("t5_err_held",  64'(cfg_err),   64'd1);
    check("t5_oe_held",   64'(pad_oe),    64'h0F);
    Reset = 1'b1;
    #1;
    check("t5_ready_rst", 64'(cfg_ready), 64'd0);
    tick();
    Reset = 1'b0;
    #1;
    check("t5_err_clr",   64'(cfg_err),   64'd0);
    check("t5_oe_clr",    64'(pad_oe),    64'h00);
    check("t5_out_clr",   64'(pad_out),   64'h00);
    check("t5_io_in",     64'(io_in),     64'h01);

    // 6: reset during WL_PULSE aborts the write
    send(2'd0, 8'hFF);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("t6_oe_abort",  64'(pad_oe),    64'h00);
    check("t6_ready",     64'(cfg_ready), 64'd1);
    tick();
    check("t6_oe_late",   64'(pad_oe),    64'h00);
    send(2'd0, 8'h33);
    tick();
    tick();
    check("t6_oe_new",    64'(pad_oe),    64'h33);
    tick();
    check("t6_ready_end", 64'(cfg_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/grid_io_cfg_bank.md
Name: grid_io_cfg_bank

Overview:
Parametrised I/O grid column of NUM_IO pads with its own configuration loader, replacing externally driven bl/wl pins.
- Accepts configuration frames over a valid/ready port.
- Sequences bit-line setup, word-line pulse and hold internally into a per-pad configuration memory.
- Applies per-pad mode (direction, input synchroniser, output register) to the pad/fabric data path.
- Sits at the fabric edge between the routing fabric (io_in/io_out) and pad drivers.

Parameters:
NUM_IO, 8, number of pads in the bank (1..64)
SYNC_STAGES, 2, input synchroniser depth when IREG set (1..3)
CFG_BITS, 3, localparam, config bits per pad: bit0 OE, bit1 IREG, bit2 OREG
AW, 2, localparam, word-line address width = max(1, clog2(CFG_BITS))

Ports:
clk  input  1  single clock for configuration and data path
Reset  input  1  synchronous, active-high reset
cfg_valid  input  1  configuration frame valid
cfg_ready  output  1  loader can accept a frame
cfg_wl_addr  input  AW  word line (config bit index) to write
cfg_bl_data  input  NUM_IO  bit-line data, one bit per pad
cfg_err  output  1  sticky: frame with cfg_wl_addr >= CFG_BITS received
pad_in  input  NUM_IO  value sampled from pad receiver
pad_out  output  NUM_IO  value to pad driver
pad_oe  output  NUM_IO  pad driver enable (1 = output mode)
io_out  input  NUM_IO  fabric data to pad
io_in  output  NUM_IO  pad data to fabric

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, Reset.
- Reset, sampled at a clk edge, sets:
  - FSM to IDLE, all config memory to 0 (all pads input, unregistered).
  - cfg_err=0, internal bl/wl=0, synchroniser and output registers=0.
  - Outputs after that edge: cfg_ready=1, pad_oe=0, pad_out=0, io_in=pad_in.
- Handshake: a transfer occurs on an edge with cfg_valid && cfg_ready. cfg_ready=1 only in IDLE with Reset low.
- FSM states:
  - IDLE: on a transfer with a valid address, latch addr/data, go to BL_SETUP.
  - BL_SETUP: drive bl=latched data, wl=0. Go to WL_PULSE.
  - WL_PULSE: assert one-hot wl[addr] for exactly one cycle; memory row addr captures bl at the end of this cycle. Go to BL_HOLD.
  - BL_HOLD: wl=0, bl held. Go to IDLE.
  - The BL_SETUP -> WL_PULSE -> BL_HOLD -> IDLE sequence is unconditional.
- Timing:
  - cfg_ready is low for 3 cycles after an accepted valid frame; maximum throughput is 1 frame per 4 cycles.
  - New configuration affects pad_oe/pad_out/io_in from the cycle after WL_PULSE, i.e. 2 edges after acceptance.
- Invalid address (>= CFG_BITS):
  - Frame is consumed; cfg_err set and held until Reset; memory unchanged.
  - FSM stays in IDLE and cfg_ready stays 1.
- Reset mid-sequence (any state): abort without a partial write; all rows cleared; cfg_ready=1 after the reset edge.
- Data path per pad i:
  - pad_oe[i] = OE[i].
  - pad_out[i] = OE ? (OREG ? io_out[i] delayed 1 clk : io_out[i]) : 0.
  - io_in[i] = OE ? 0 : (IREG ? last of SYNC_STAGES flops of pad_in[i] : pad_in[i]).
  - Synchroniser and output register run every cycle regardless of mode; changing IREG/OREG does not clear them.
- No pad-to-pad interaction; all widths are NUM_IO with no truncation.

Decomposition:
- Package grid_io_cfg_pkg:
  - CFG_BITS, bit indices CFG_OE=0, CFG_IREG=1, CFG_OREG=2.
  - FSM state enum {IDLE, BL_SETUP, WL_PULSE, BL_HOLD}.
  - Helper for AW.
- Sub-module io_pad_slice, instantiated NUM_IO times:
  - Holds one pad's CFG_BITS memory cells (written by bl/wl).
  - Holds the synchroniser, output register and muxing.
- The top level holds the loader FSM, latches and cfg_err.

Test Plan:
1. Reset, NUM_IO=8 -> cfg_ready=1, cfg_err=0, pad_oe=0x00, pad_out=0x00; pad_in=0x5A gives io_in=0x5A in the same cycle.
2. Write addr 0, data 0xA5 -> cfg_ready low for exactly 3 cycles; pad_oe=0xA5 two edges after acceptance; io_in=0x5A&~0xA5=0x5A; pad_out=io_out&0xA5.
3. Write addr 1, data 0xFF, SYNC_STAGES=2, OE=0; toggle pad_in[0] 0->1 -> io_in[0] rises after exactly 2 clk edges.
4. Write OE=0x0F, then OREG addr 2 with 0xFF; io_out=0x3C -> pad_out=0x0C one cycle later; pads 4..7 pad_out=0.
5. Frame addr 3, data 0xFF -> cfg_err=1 and stays 1; cfg_ready stays 1; pad_oe unchanged; Reset clears cfg_err.
6. Accept addr 0 / 0xFF, assert Reset in the WL_PULSE cycle -> pad_oe=0x00 after the reset edge, cfg_ready=1; a following frame completes normally.
